// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder.
// Command bytes, one-hot indices, FSM states, default NAK byte.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPT,
    DEC,
    ECHO
  } state_t;

  localparam logic [7:0] ASC_R = 8'h52;
  localparam logic [7:0] ASC_L = 8'h4C;
  localparam logic [7:0] ASC_U = 8'h55;
  localparam logic [7:0] ASC_D = 8'h44;
  localparam logic [7:0] ASC_F = 8'h46;
  localparam logic [7:0] ASC_W = 8'h57;
  localparam logic [7:0] ASC_C = 8'h43;

  localparam int CMD_R = 0;
  localparam int CMD_L = 1;
  localparam int CMD_U = 2;
  localparam int CMD_D = 3;
  localparam int CMD_F = 4;
  localparam int CMD_W = 5;
  localparam int CMD_C = 6;
  localparam int CMD_N = 7;

  localparam logic [7:0] NAK_DEF = 8'h3F;

  function automatic logic [7:0] to_upper(
    input logic [7:0] b
  );
    logic [7:0] r;
    r = b;
    if (b >= 8'h61 && b <= 8'h7A)
      r = b - 8'h20;
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_lut.sv
// Byte to one-hot command map with a known flag.
// Purely combinational; case folding set by CASE_INSENSITIVE.
module uart_cmd_lut
  import uart_cmd_pkg::*;
#(
  parameter bit CASE_INSENSITIVE = 1'b1
) (
  input  logic [7:0]       data,
  output logic [CMD_N-1:0] cmd_oh,
  output logic             known
);

  logic [7:0] c;

  always_comb begin
    c = CASE_INSENSITIVE ? to_upper(data) : data;
    cmd_oh = '0;
    unique case (1'b1)
      (c == ASC_R): cmd_oh[CMD_R] = 1'b1;
      (c == ASC_L): cmd_oh[CMD_L] = 1'b1;
      (c == ASC_U): cmd_oh[CMD_U] = 1'b1;
      (c == ASC_D): cmd_oh[CMD_D] = 1'b1;
      (c == ASC_F): cmd_oh[CMD_F] = 1'b1;
      (c == ASC_W): cmd_oh[CMD_W] = 1'b1;
      (c == ASC_C): cmd_oh[CMD_C] = 1'b1;
      default: ;
    endcase
    known = |cmd_oh;
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART RX byte -> virtual button pulses / switch toggles.
// Define UART_CMD_ECHO_EN to echo each byte (or NAK) to TX.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter bit         CASE_INSENSITIVE = 1'b1,
  parameter logic [7:0] NAK_CHAR         = NAK_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_rdata,
  output logic       rx_fifo_pop,
  input  logic       tx_fifo_full,
  output logic       tx_fifo_push,
  output logic [7:0] tx_fifo_wdata,
  output logic       cmd_btn_r,
  output logic       cmd_btn_l,
  output logic       cmd_btn_u,
  output logic       cmd_btn_d,
  output logic       cmd_sw_fmt,
  output logic       cmd_sw_wtch,
  output logic       cmd_sw_calib
);

  state_t           state;
  logic [7:0]       byte_q;
  logic [CMD_N-1:0] cmd_oh;
  logic             known;

  uart_cmd_lut #(
    .CASE_INSENSITIVE(CASE_INSENSITIVE)
  ) u_lut (
    .data   (byte_q),
    .cmd_oh (cmd_oh),
    .known  (known)
  );

`ifndef UART_CMD_ECHO_EN
  logic unused_ok;
  assign unused_ok     = ^{tx_fifo_full, known};
  assign tx_fifo_push  = 1'b0;
  assign tx_fifo_wdata = 8'h00;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      byte_q       <= 8'h00;
      rx_fifo_pop  <= 1'b0;
      cmd_btn_r    <= 1'b0;
      cmd_btn_l    <= 1'b0;
      cmd_btn_u    <= 1'b0;
      cmd_btn_d    <= 1'b0;
      cmd_sw_fmt   <= 1'b0;
      cmd_sw_wtch  <= 1'b0;
      cmd_sw_calib <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      tx_fifo_push  <= 1'b0;
      tx_fifo_wdata <= 8'h00;
`endif
    end else begin
      rx_fifo_pop <= 1'b0;
      cmd_btn_r   <= 1'b0;
      cmd_btn_l   <= 1'b0;
      cmd_btn_u   <= 1'b0;
      cmd_btn_d   <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      tx_fifo_push <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!rx_fifo_empty) begin
            state       <= POP;
            rx_fifo_pop <= 1'b1;
          end
        end
        POP: state <= CAPT;
        CAPT: begin
          byte_q <= rx_fifo_rdata;
          state  <= DEC;
        end
        DEC: begin
          cmd_btn_r    <= cmd_oh[CMD_R];
          cmd_btn_l    <= cmd_oh[CMD_L];
          cmd_btn_u    <= cmd_oh[CMD_U];
          cmd_btn_d    <= cmd_oh[CMD_D];
          cmd_sw_fmt   <= cmd_sw_fmt ^ cmd_oh[CMD_F];
          cmd_sw_wtch  <= cmd_sw_wtch ^ cmd_oh[CMD_W];
          cmd_sw_calib <= cmd_sw_calib ^ cmd_oh[CMD_C];
`ifdef UART_CMD_ECHO_EN
          state <= ECHO;
`else
          state <= IDLE;
`endif
        end
`ifdef UART_CMD_ECHO_EN
        // Stall here while TX is full; no further pops.
        ECHO: begin
          if (!tx_fifo_full) begin
            tx_fifo_push  <= 1'b1;
            tx_fifo_wdata <= known ? byte_q : NAK_CHAR;
            state         <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
